// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the microRISC memory-access stage.
//   - mem_state_e : access FSM encoding (IDLE / WAIT)
//   - wb_fields_t : contents of the MEM/WB pipeline register
//   - DATA_W, REG_W, DEF_TIMEOUT, DEF_CNT_W : widths and default limits
package mem_stage_pkg;

    localparam int DATA_W      = 16;
    localparam int REG_W       = 3;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
        logic [REG_W-1:0]  write_reg;
    } wb_fields_t;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all fields)
//   en         : load d into q
//   bubble     : clear the control bits (reg_write, mem_to_reg), hold data
//   flush      : clear every field
//   d / q      : register input / output fields
// Priority: flush > bubble > en.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       bubble,
    input  logic       flush,
    input  wb_fields_t d,
    output wb_fields_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (bubble) begin
            q.reg_write  <= 1'b0;
            q.mem_to_reg <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the microRISC pipeline.
// Drives the data-memory req/ack bus for loads/stores, stalls upstream
// while an access is outstanding, aborts after TIMEOUT request cycles and
// holds the MEM/WB register feeding write-back and forwarding.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : kill the instruction currently in MEM
//   mem_*                   : EX/MEM pipeline register fields
//   dmem_req/we/addr/wdata  : data-memory request side
//   dmem_rdata/ack          : data-memory response side
//   mem_stall               : freeze the upstream pipeline this cycle
//   mem_fault, fault_clr    : sticky fault flag and its clear
//   wb_*                    : MEM/WB register outputs
//   dbg_state               : current access FSM state
//
// Bus handshake: dmem_req is held high with dmem_addr/dmem_we/dmem_wdata
// stable until a rising edge where dmem_ack is also high (that edge
// completes the access, dmem_rdata is sampled with it), or until the
// stage aborts on timeout. dmem_ack while dmem_req is low is ignored.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic              mem_mem_write,
    input  logic              mem_mem_to_reg,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [REG_W-1:0]  mem_write_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              mem_fault,
    input  logic              fault_clr,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [REG_W-1:0]  wb_write_reg,
    output mem_state_e        dbg_state
);

    mem_state_e        state;
    logic [CNT_W-1:0]  cnt;

    // Holding registers for the outstanding access
    logic [DATA_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_we;
    logic              h_reg_write;
    logic              h_mem_to_reg;
    logic              h_is_load;
    logic [REG_W-1:0]  h_write_reg;
    logic              h_flush;

    logic       access;
    logic       idle_go;
    logic       timeout_hit;
    logic       wait_done;
    logic       fault_set;

    logic       wb_en;
    logic       wb_bubble;
    logic       wb_flush;
    wb_fields_t wb_d;
    wb_fields_t wb_q;

    assign access  = mem_mem_read | mem_mem_write;
    // A flushed instruction never reaches the bus
    assign idle_go = (state == S_IDLE) & access & ~flush;
    // cnt is 1 in the first WAIT cycle (the IDLE request cycle counts as
    // the first), so the abort cycle is the TIMEOUT-th request cycle.
    assign timeout_hit = (state == S_WAIT) & ~dmem_ack
                         & (cnt == CNT_W'(TIMEOUT - 1));
    assign wait_done   = (state == S_WAIT) & (dmem_ack | timeout_hit);
    assign fault_set   = (idle_go & mem_mem_read & mem_mem_write) | timeout_hit;

    // Bus and stall outputs; all forced low while reset is asserted
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        mem_stall  = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    if (idle_go) begin
                        dmem_req   = 1'b1;
                        dmem_addr  = mem_alu_result;
                        dmem_wdata = mem_write_data;
                        dmem_we    = mem_mem_write & ~mem_mem_read;
                        mem_stall  = ~dmem_ack;
                    end
                end
                S_WAIT: begin
                    dmem_req   = 1'b1;
                    dmem_addr  = h_addr;
                    dmem_wdata = h_wdata;
                    dmem_we    = h_we;
                    mem_stall  = ~(dmem_ack | timeout_hit);
                end
                default: ;
            endcase
        end
    end

    // MEM/WB input selection
    always_comb begin
        wb_d      = '0;
        wb_en     = 1'b0;
        wb_bubble = 1'b0;
        wb_flush  = 1'b0;
        if (state == S_IDLE) begin
            wb_flush        = flush;
            wb_bubble       = mem_stall;
            wb_en           = 1'b1;
            wb_d.reg_write  = mem_reg_write;
            wb_d.mem_to_reg = mem_mem_to_reg;
            wb_d.alu_result = mem_alu_result;
            wb_d.read_data  = mem_mem_read ? dmem_rdata : '0;
            wb_d.write_reg  = mem_write_reg;
        end else begin
            wb_en           = wait_done;
            wb_bubble       = ~wait_done;
            // A flush seen at any point during WAIT squashes the write-back
            wb_d.reg_write  = h_reg_write & ~(h_flush | flush);
            wb_d.mem_to_reg = h_mem_to_reg;
            wb_d.alu_result = h_addr;
            // Aborted loads complete with zero data (dmem_ack is low then)
            wb_d.read_data  = (h_is_load & dmem_ack) ? dmem_rdata : '0;
            wb_d.write_reg  = h_write_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            h_addr       <= '0;
            h_wdata      <= '0;
            h_we         <= 1'b0;
            h_reg_write  <= 1'b0;
            h_mem_to_reg <= 1'b0;
            h_is_load    <= 1'b0;
            h_write_reg  <= '0;
            h_flush      <= 1'b0;
            mem_fault    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (idle_go && !dmem_ack) begin
                        state        <= S_WAIT;
                        cnt          <= CNT_W'(1);
                        h_addr       <= mem_alu_result;
                        h_wdata      <= mem_write_data;
                        h_we         <= mem_mem_write & ~mem_mem_read;
                        h_reg_write  <= mem_reg_write;
                        h_mem_to_reg <= mem_mem_to_reg;
                        h_is_load    <= mem_mem_read;
                        h_write_reg  <= mem_write_reg;
                        h_flush      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        h_flush <= 1'b1;
                    end
                    if (wait_done) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Setting the fault wins over a simultaneous clear
            if (fault_set) begin
                mem_fault <= 1'b1;
            end else if (fault_clr) begin
                mem_fault <= 1'b0;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (wb_en),
        .bubble (wb_bubble),
        .flush  (wb_flush),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_read_data  = wb_q.read_data;
    assign wb_write_reg  = wb_q.write_reg;
    assign dbg_state     = state;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage microRISC pipeline. Sits between the EX/MEM pipeline register and write-back.
- Drives a variable-latency data-memory req/ack bus for loads and stores. Stalls upstream stages while an access is outstanding, with timeout-based fault recovery.
- Includes the MEM/WB pipeline register; its outputs feed the WB mux and the forwarding unit directly.

Parameters:
- TIMEOUT, 16: max cycles dmem_req may stay high without dmem_ack before abort (2..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  turn the instruction currently in MEM into a bubble
- mem_reg_write  in  1  from EX/MEM
- mem_mem_read  in  1  load
- mem_mem_write  in  1  store
- mem_mem_to_reg  in  1  WB selects load data
- mem_alu_result  in  16  address, or pass-through result
- mem_write_data  in  16  store data
- mem_write_reg  in  3  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  16  word address
- dmem_wdata  out  16  store data
- dmem_rdata  in  16  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- mem_fault  out  1  sticky timeout/illegal-access flag
- fault_clr  in  1  clears mem_fault
- wb_reg_write  out  1  to WB
- wb_mem_to_reg  out  1
- wb_alu_result  out  16
- wb_read_data  out  16
- wb_write_reg  out  3

Behaviour:
- Reset: clk and rst_n per the already-decided rule: one clock; reset is asynchronous and active-low. Reset forces state=IDLE, counter=0 and mem_fault=0. All wb_* outputs reset to 0. dmem_req, dmem_we and mem_stall are 0 during reset. Reset mid-WAIT abandons the access; no ack is expected afterwards.
- access = mem_mem_read | mem_mem_write.
- Both read and write set: treated as a read. dmem_we=0 and mem_fault is set.
- IDLE state:
  - If access, assert dmem_req combinationally with dmem_addr=mem_alu_result, dmem_wdata=mem_write_data, dmem_we=mem_mem_write & ~mem_mem_read.
  - If dmem_ack arrives the same cycle (zero-wait), the access completes. The MEM/WB register loads at this edge and mem_stall=0.
  - Otherwise mem_stall=1. Capture addr/wdata/we, the control bits and write_reg into internal holding registers, then go to WAIT.
  - Non-access instructions pass to MEM/WB every cycle, with no stall.
- WAIT state:
  - dmem_req=1 and dmem_addr/wdata/we come from the holding registers, stable until ack. mem_stall=1. The counter increments each cycle.
  - On dmem_ack: mem_stall=0 that cycle; MEM/WB loads the held instruction with wb_read_data=dmem_rdata; go to IDLE.
  - If counter reaches TIMEOUT-1 without ack: abort. dmem_req drops next cycle and mem_stall=0 that cycle. The instruction completes with wb_read_data=16'h0000, mem_fault is set, and the state returns to IDLE.
- A late dmem_ack arriving in IDLE with no access outstanding is ignored.
- MEM/WB register:
  - On completion, wb_* takes the stage inputs (or held values); wb_read_data takes dmem_rdata, or 0 for non-loads.
  - While mem_stall=1, wb_reg_write<=0 and wb_mem_to_reg<=0 (bubble). Data fields hold.
- Flush:
  - In IDLE with no access: the MEM/WB outputs become a bubble (wb_reg_write=0, all fields 0) and no dmem_req is issued.
  - flush during WAIT cannot cancel the bus access. It is latched and applied on completion, so wb_reg_write=0 for that instruction.
- mem_fault: set wins over fault_clr in the same cycle.
- Loads have 1 cycle of latency from ack to wb_read_data visibility.

Decomposition:
- Shared package/defines: FSM state encoding (IDLE=1'b0, WAIT=1'b1), data width 16, register-index width 3, and the default TIMEOUT value.
- Natural sub-module: mem_wb_reg, holding the WB-side register with enable/bubble/flush inputs, mirroring the existing pipeline-register style. The FSM and timeout counter stay in mem_stage.

Test Plan:
- Zero-wait load: read=1, addr=0x0010, ack same cycle with rdata=0xBEEF, write_reg=3 -> mem_stall never asserted; next cycle wb_read_data=0xBEEF, wb_write_reg=3, wb_reg_write=1.
- 3-wait store: write=1, addr=0x0020, wdata=0x1234, ack on the 4th cycle -> mem_stall=1 for 3 cycles; dmem_addr/wdata/we stable throughout; wb_reg_write=0 during the stall; completes with wb_reg_write=mem_reg_write (0).
- Timeout with TIMEOUT=4 and no ack -> dmem_req high for 4 cycles then drops; mem_fault=1; wb_read_data=0x0000; a fault_clr pulse returns mem_fault to 0.
- Flush mid-WAIT on a load, ack 2 cycles later with rdata=0x5555 -> dmem_req held until ack; the completing instruction has wb_reg_write=0.
- rst_n low during WAIT -> dmem_req, mem_stall and all wb_* are 0 immediately (asynchronous); a subsequent ALU instruction (result 0x00AA, reg 5) passes with wb_alu_result=0x00AA one cycle later.
- Read and write both set -> treated as a read (dmem_we=0); mem_fault=1.
